// File: rtl/led_pattern_gen.sv
// LED pattern engine: four display modes (binary count, bouncing scan, PWM breathe, blink)
// selected by a debounced mode button, with a debounced hold button that freezes the pattern.
module led_pattern_gen #(
  parameter int unsigned NUM_LEDS        = 8,
  parameter int unsigned CTR_WIDTH       = 32,
  parameter int unsigned STEP_SHIFT      = 18,
  parameter int unsigned PWM_WIDTH       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_btn_mode,
  input  logic                i_btn_hold,
  output logic [NUM_LEDS-1:0] o_led,
  output logic [1:0]          o_mode
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PosW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  // Button index 0 is mode, index 1 is hold.
  localparam int unsigned BtnMode = 0;
  localparam int unsigned BtnHold = 1;

  typedef enum logic [1:0] {
    ModeBinary  = 2'd0,
    ModeScan    = 2'd1,
    ModeBreathe = 2'd2,
    ModeBlink   = 2'd3
  } mode_e;

  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          deb_q, deb_d;
  logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;
  logic                mode_prev_q;

  logic [CTR_WIDTH-1:0] ctr_q, ctr_d;
  logic [PWM_WIDTH-1:0] pwm_q, pwm_d;

  mode_e                mode_q, mode_d;
  logic [PosW-1:0]      pos_q, pos_d;
  logic                 dir_up_q, dir_up_d;
  logic [PWM_WIDTH-1:0] duty_q, duty_d;
  logic                 blink_q, blink_d;
  logic [NUM_LEDS-1:0]  led_q, led_d;

  logic mode_pulse;
  logic hold;
  logic tick;
  logic unused_ctr;

  // Debounce: count consecutive cycles the synchronised level disagrees with the accepted one.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != deb_q[b]) begin
        if (db_cnt_q[b] == DbW'(DEBOUNCE_CYCLES)) begin
          deb_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DbW'(1);
        end
      end
    end
  end

  assign mode_pulse = deb_q[BtnMode] & ~mode_prev_q;
  assign hold       = deb_q[BtnHold];
  assign tick       = (&ctr_q[STEP_SHIFT-1:0]) & ~hold;
  // Bits above the displayed window only extend the binary count's period.
  assign unused_ctr = ^ctr_q;

  // Free-running counters; the step counter stops while hold is accepted.
  always_comb begin
    ctr_d = hold ? ctr_q : ctr_q + CTR_WIDTH'(1);
    pwm_d = pwm_q + PWM_WIDTH'(1);
  end

  // Mode/pattern next state: a mode change reinitialises pattern state and swallows any tick.
  always_comb begin
    mode_d   = mode_q;
    pos_d    = pos_q;
    dir_up_d = dir_up_q;
    duty_d   = duty_q;
    blink_d  = blink_q;
    if (mode_pulse) begin
      unique case (mode_q)
        ModeBinary:  mode_d = ModeScan;
        ModeScan:    mode_d = ModeBreathe;
        ModeBreathe: mode_d = ModeBlink;
        ModeBlink:   mode_d = ModeBinary;
        default:     mode_d = ModeBinary;
      endcase
      pos_d    = '0;
      dir_up_d = 1'b1;
      duty_d   = '0;
      blink_d  = 1'b0;
    end else if (tick) begin
      unique case (mode_q)
        ModeScan: begin
          if (NUM_LEDS > 1) begin
            if (dir_up_q) begin
              if (pos_q == PosW'(NUM_LEDS - 1)) begin
                dir_up_d = 1'b0;
                pos_d    = pos_q - PosW'(1);
              end else begin
                pos_d = pos_q + PosW'(1);
              end
            end else begin
              if (pos_q == '0) begin
                dir_up_d = 1'b1;
                pos_d    = pos_q + PosW'(1);
              end else begin
                pos_d = pos_q - PosW'(1);
              end
            end
          end
        end
        ModeBreathe: begin
          if (dir_up_q) begin
            if (duty_q == '1) begin
              dir_up_d = 1'b0;
              duty_d   = duty_q - PWM_WIDTH'(1);
            end else begin
              duty_d = duty_q + PWM_WIDTH'(1);
            end
          end else begin
            if (duty_q == '0) begin
              dir_up_d = 1'b1;
              duty_d   = duty_q + PWM_WIDTH'(1);
            end else begin
              duty_d = duty_q - PWM_WIDTH'(1);
            end
          end
        end
        ModeBlink:  blink_d = ~blink_q;
        ModeBinary: ;
        default:    ;
      endcase
    end
  end

  // LED drive decoded from the current (pre-edge) mode and pattern state.
  always_comb begin
    led_d = '0;
    unique case (mode_q)
      ModeBinary:  led_d = ctr_q[STEP_SHIFT +: NUM_LEDS];
      ModeScan:    led_d = NUM_LEDS'(1) << pos_q;
      ModeBreathe: led_d = {NUM_LEDS{pwm_q < duty_q}};
      ModeBlink:   led_d = {NUM_LEDS{blink_q}};
      default:     led_d = '0;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      db_cnt_q    <= '0;
      mode_prev_q <= 1'b0;
      ctr_q       <= '0;
      pwm_q       <= '0;
      mode_q      <= ModeBinary;
      pos_q       <= '0;
      dir_up_q    <= 1'b1;
      duty_q      <= '0;
      blink_q     <= 1'b0;
      led_q       <= '0;
    end else begin
      sync1_q     <= {i_btn_hold, i_btn_mode};
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      db_cnt_q    <= db_cnt_d;
      mode_prev_q <= deb_q[BtnMode];
      ctr_q       <= ctr_d;
      pwm_q       <= pwm_d;
      mode_q      <= mode_d;
      pos_q       <= pos_d;
      dir_up_q    <= dir_up_d;
      duty_q      <= duty_d;
      blink_q     <= blink_d;
      led_q       <= led_d;
    end
  end

  assign o_led  = led_q;
  assign o_mode = mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with short debounce and tick periods.
module tb_led_pattern_gen;

  localparam int unsigned NL = 4;

  logic          clk;
  logic          rst_n;
  logic          btn_mode;
  logic          btn_hold;
  logic [NL-1:0] led;
  logic [1:0]    mode;

  int t;
  int checks;
  int errors;

  led_pattern_gen #(
    .NUM_LEDS        (NL),
    .CTR_WIDTH       (8),
    .STEP_SHIFT      (2),
    .PWM_WIDTH       (3),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_btn_mode (btn_mode),
    .i_btn_hold (btn_hold),
    .o_led      (led),
    .o_mode     (mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         t;
    logic [3:0] led;
    logic [1:0] mode;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic run_to(input int n);
    while (t < n) step();
  endtask

  task automatic do_reset(input int cycles);
    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_hold = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      chk("reset_led", 32'(led), 32'h0);
      chk("reset_mode", 32'(mode), 32'h0);
    end
    rst_n = 1'b1;
    t     = 0;
  endtask

  // Triangle duty after j ticks from duty=0 going up (max 7).
  function automatic int tri_duty(input int j);
    int r;
    r = j % 14;
    return (r <= 7) ? r : 14 - r;
  endfunction

  // Expected BREATHE output after edge n; ticks land on multiples of 4, base = entry edge / 4.
  function automatic logic [3:0] exp_breathe(input int n, input int base);
    int duty;
    duty = tri_duty(((n - 1) / 4) - base);
    return (((n - 1) % 8) < duty) ? 4'hF : 4'h0;
  endfunction

  initial begin
    int seq[6];
    int ons;
    seq = '{0, 1, 2, 3, 2, 1};
    t = 0;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    btn_mode = 1'b0;
    btn_hold = 1'b0;

    // BINARY: o_led after edge t shows ctr = t-1, bits [5:2].
    vecs[0] = '{t: 1,  led: 4'h0, mode: 2'd0};
    vecs[1] = '{t: 4,  led: 4'h0, mode: 2'd0};
    vecs[2] = '{t: 5,  led: 4'h1, mode: 2'd0};
    vecs[3] = '{t: 8,  led: 4'h1, mode: 2'd0};
    vecs[4] = '{t: 9,  led: 4'h2, mode: 2'd0};
    vecs[5] = '{t: 20, led: 4'h4, mode: 2'd0};
    vecs[6] = '{t: 64, led: 4'hF, mode: 2'd0};
    vecs[7] = '{t: 65, led: 4'h0, mode: 2'd0};
    vecs[8] = '{t: 68, led: 4'h0, mode: 2'd0};
    vecs[9] = '{t: 69, led: 4'h1, mode: 2'd0};

    do_reset(3);
    for (int i = 0; i < 10; i++) begin
      run_to(vecs[i].t);
      chk("binary_led", 32'(led), 32'(vecs[i].led));
      chk("binary_mode", 32'(mode), 32'(vecs[i].mode));
    end

    // Debounce: three 3-clock bounces must not register.
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      run_to(8 * i);
      btn_mode = 1'b1;
      run_to(8 * i + 3);
      btn_mode = 1'b0;
      run_to(8 * i + 7);
      chk("bounce_mode", 32'(mode), 32'h0);
    end
    run_to(25);
    btn_mode = 1'b1;  // first sampled at edge 26
    run_to(32);
    chk("press_mode_early", 32'(mode), 32'h0);
    run_to(33);
    chk("press_mode_k7", 32'(mode), 32'h1);
    chk("press_led_lag", 32'(led), 32'h8);
    run_to(34);
    chk("scan_start", 32'(led), 32'h1);
    run_to(35);
    btn_mode = 1'b0;

    // SCAN: one tick every 4 edges; sample mid-period.
    for (int i = 1; i <= 28; i++) begin
      run_to(34 + 4 * i);
      chk("scan_seq", 32'(led), 32'(1 << seq[i % 6]));
    end
    chk("scan_single_press", 32'(mode), 32'h1);

    // BREATHE: entered at edge 154, ramp checked every clock; hold freezes duty at 3.
    run_to(146);
    btn_mode = 1'b1;
    run_to(153);
    chk("breathe_mode_early", 32'(mode), 32'h1);
    run_to(154);
    chk("breathe_mode", 32'(mode), 32'h2);
    for (int n = 155; n <= 224; n++) begin
      run_to(n);
      if (n == 156) btn_mode = 1'b0;
      if (n == 214) btn_hold = 1'b1;
      chk("breathe_ramp", 32'(led), 32'(exp_breathe(n, 38)));
    end
    for (int w = 0; w < 2; w++) begin
      ons = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (led == 4'hF) ons++;
      end
      chk("breathe_duty3_window", 32'(ons), 32'd3);
    end
    chk("breathe_mode_held", 32'(mode), 32'h2);

    // Collisions, blink, hold, mode change under hold.
    do_reset(2);
    btn_mode = 1'b1;  // mode 1 lands on the tick edge 8
    run_to(7);
    chk("coll1_mode_early", 32'(mode), 32'h0);
    run_to(8);
    chk("coll1_mode", 32'(mode), 32'h1);
    run_to(9);
    chk("coll1_no_step", 32'(led), 32'h1);
    run_to(10);
    btn_mode = 1'b0;
    run_to(12);
    chk("coll1_pos0", 32'(led), 32'h1);
    run_to(13);
    chk("coll1_pos1", 32'(led), 32'h2);
    run_to(20);
    btn_mode = 1'b1;  // mode 2 lands on the tick edge 28
    run_to(28);
    chk("coll2_mode", 32'(mode), 32'h2);
    for (int n = 29; n <= 40; n++) begin
      run_to(n);
      if (n == 30) btn_mode = 1'b0;
      chk("coll2_breathe", 32'(led), 32'(exp_breathe(n, 7)));
    end
    btn_mode = 1'b1;  // mode 3 at edge 48
    run_to(48);
    chk("blink_mode", 32'(mode), 32'h3);
    for (int n = 49; n <= 68; n++) begin
      run_to(n);
      if (n == 50) btn_mode = 1'b0;
      if (n == 62) btn_hold = 1'b1;  // accepted at edge 69
      chk("blink_seq", 32'(led), (((((n - 1) / 4) - 12) % 2) != 0) ? 32'hF : 32'h0);
    end
    for (int n = 69; n <= 90; n++) begin
      run_to(n);
      chk("blink_frozen", 32'(led), 32'hF);
    end
    btn_mode = 1'b1;  // press while held
    run_to(97);
    chk("held_mode_early", 32'(mode), 32'h3);
    run_to(98);
    chk("held_mode_wrap", 32'(mode), 32'h0);
    for (int n = 99; n <= 110; n++) begin
      run_to(n);
      if (n == 100) btn_mode = 1'b0;
      chk("held_ctr_frozen", 32'(led), 32'h1);  // ctr frozen at 69
    end

    // Reset in the middle of a debounce: the press is lost.
    btn_mode = 1'b1;
    run_to(113);
    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_hold = 1'b0;
    step();
    chk("midreset_led", 32'(led), 32'h0);
    chk("midreset_mode", 32'(mode), 32'h0);
    rst_n = 1'b1;
    t     = 0;
    run_to(10);
    chk("midreset_lost", 32'(mode), 32'h0);
    run_to(20);
    chk("midreset_lost_late", 32'(mode), 32'h0);
    chk("midreset_binary", 32'(led), 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern engine for the board's user LEDs, driven from the 25 MHz board clock. Provides four selectable display modes: binary count, bouncing scan, PWM breathe and blink. Two raw push-buttons are debounced internally: one cycles the mode, one freezes the pattern. Instantiated in the board top between the button pins and the LED pins, replacing the hard-wired free-running counter display.

## Interface

Parameters:
- NUM_LEDS, 8: number of LED outputs (>= 1).
- CTR_WIDTH, 32: free-running step counter width. Must be >= STEP_SHIFT + NUM_LEDS.
- STEP_SHIFT, 18: pattern tick period is 2^STEP_SHIFT clocks (about 10.5 ms at 25 MHz).
- PWM_WIDTH, 8: PWM counter and breathe duty width.
- DEBOUNCE_CYCLES, 250000: consecutive stable clocks required to accept a button change (>= 1).

Ports:
- i_clk, input, 1: system clock (board clk_25mhz).
- i_rst_n, input, 1: reset; synchronous, active-low.
- i_btn_mode, input, 1: raw mode button, asynchronous, active-high.
- i_btn_hold, input, 1: raw hold button, asynchronous, active-high.
- o_led, output, NUM_LEDS: registered LED drive, 1 = on.
- o_mode, output, 2: current mode, registered.

## Operation

Reset (i_rst_n low at a clock edge):
- ctr = 0, pwm_cnt = 0, mode = 0, pos = 0, dir = up, duty = 0, blink = 0.
- Synchronisers, debounced levels and debounce counters = 0.
- o_led = 0, o_mode = 0.
- Reset has priority over every other event, including mid-debounce and mid-pattern.

Debounce, per button:
- Each raw input passes through a 2-flop synchroniser.
- A counter increments while the synchronised value differs from the debounced level and clears when they match.
- When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
- A rising edge of the debounced mode level produces a one-cycle mode_pulse.

Counters and tick:
- pwm_cnt increments every cycle, free-running and wrapping.
- ctr increments every cycle unless the debounced hold level is high.
- tick = (ctr[STEP_SHIFT-1:0] all ones) and not held.

Mode register:
- mode_pulse advances mode 0 -> 1 -> 2 -> 3 -> 0, wrapping.
- On the same edge, pos = 0, dir = up, duty = 0, blink = 0.
- Hold does not block mode changes.

Modes (o_led registered from current state):
- 0 BINARY: o_led = ctr[STEP_SHIFT+NUM_LEDS-1:STEP_SHIFT].
- 1 SCAN: o_led one-hot at pos. On tick, pos steps in dir. At pos = NUM_LEDS-1 with dir up, dir flips and the next step goes to NUM_LEDS-2; symmetric at 0. Sequence for NUM_LEDS=4: 0,1,2,3,2,1,0,1... For NUM_LEDS = 1, pos stays 0.
- 2 BREATHE: all bits = (pwm_cnt < duty). On tick, duty moves by 1 in dir, reversing at 2^PWM_WIDTH-1 and at 0 (triangle wave). duty = 0 means fully off.
- 3 BLINK: blink toggles on tick; all bits = blink.

Hold:
- Freezes ctr, so there are no ticks; pattern state stays constant.
- pwm_cnt keeps running, so BREATHE stays lit at the frozen duty.

Simultaneous mode_pulse and tick: mode change wins. New-mode state is initialised as above and the tick is discarded.

## Timing

- Raw button edge sampled at edge k: synchronised at k+2, debounced level changes at k+2+DEBOUNCE_CYCLES (input held stable throughout).
- mode / o_mode update one edge after the debounced level rises; o_led reflects the new mode one further edge later.
- Debounced hold high stops ctr from the next edge.
- Any bounce shorter than DEBOUNCE_CYCLES clears the counter; no level change, no pulse.
- Pattern state change to o_led: 1 clock latency.
- BREATHE PWM period = 2^PWM_WIDTH clocks; each tick changes duty by exactly 1.

## Test plan

Bench parameters: NUM_LEDS=4, CTR_WIDTH=8, STEP_SHIFT=2, PWM_WIDTH=3, DEBOUNCE_CYCLES=4.

- Reset and BINARY: hold i_rst_n low 3 clocks, then release. Expect o_led=0 and o_mode=0 during reset, then o_led = ctr[5:2], incrementing every 4 clocks (0,1,2,... wrapping at 15).
- Debounce: pulse i_btn_mode high for 3 clocks, repeat 3 times -> o_mode stays 0. Then hold high for 10 clocks -> o_mode = 1 exactly at edge k+7; a single press advances mode by exactly one.
- SCAN: mode 1 over 28 ticks -> o_led sequence 0001,0010,0100,1000,0100,0010,0001,0010...
- BREATHE: mode 2 -> duty ramps 0..7..0. With duty=3, o_led=1111 for exactly 3 of every 8 clocks; with duty=0, o_led is always 0.
- Hold: in BLINK, assert i_btn_hold >= 7 clocks -> o_led constant and ctr frozen. Mode press while held still advances o_mode from 3 to 0.
- Collision and reset mid-run: align a mode_pulse with a tick in SCAN -> mode 2 is entered with duty=0 and no pos step. Assert reset mid-debounce -> all outputs 0 the next edge and the pending press is lost.
